// File: rtl/seq_divider_32_bit_if.sv
// Start/busy/done handshake and operand/result bus for the sequential divider.
interface seq_divider_32_bit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_32_bit.sv
// Multi-cycle unsigned restoring divider: one shared subtractor (a + ~b + 1),
// one trial subtraction per clock, start/busy/done handshake.
module seq_divider_32_bit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_divider_32_bit_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned SW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quotient_d;
    logic [WIDTH-1:0] remainder_d;
    logic             dbz_d;

    // Shared trial subtractor, WIDTH+1 bits wide; carry-out 1 means no borrow.
    logic [WIDTH:0]   sub_a;
    logic [WIDTH:0]   sub_b;
    logic [SW-1:0]    sub_sum;
    logic             nb;
    logic [WIDTH-1:0] t_low;
    logic             sub_unused;

    assign sub_a      = {r_q, q_q[WIDTH-1]};
    assign sub_b      = {1'b0, v_q};
    assign sub_sum    = {1'b0, sub_a} + {1'b0, ~sub_b} + SW'(1);
    assign nb         = sub_sum[WIDTH+1];
    assign t_low      = sub_sum[WIDTH-1:0];
    // When nb=1 the difference is below V, so its top bit is always zero.
    assign sub_unused = sub_sum[WIDTH];

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        v_d         = v_q;
        count_d     = count_q;
        quotient_d  = bus.quotient;
        remainder_d = bus.remainder;
        dbz_d       = bus.div_by_zero;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    v_d   = bus.divisor;
                    dbz_d = 1'b0;
                    if (bus.divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        r_d     = '0;
                        q_d     = bus.dividend;
                        count_d = CW'(WIDTH);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Partial remainder stays below V, so a shift that fails the
                // trial subtraction never overflows WIDTH bits.
                if (nb) begin
                    r_d = t_low;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    quotient_d  = q_d;
                    remainder_d = r_d;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            r_q             <= '0;
            q_q             <= '0;
            v_q             <= '0;
            count_q         <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            state_q         <= state_d;
            r_q             <= r_d;
            q_q             <= q_d;
            v_q             <= v_d;
            count_q         <= count_d;
            bus.quotient    <= quotient_d;
            bus.remainder   <= remainder_d;
            bus.div_by_zero <= dbz_d;
            bus.busy        <= (state_d != IDLE);
            bus.done        <= (state_d == DONE);
        end
    end
endmodule

// File: tb/tb_seq_divider_32_bit.sv
// Self-checking bench for seq_divider_32_bit: directed scenarios plus
// randomized back-to-back operands against a plain-arithmetic reference.
module tb_seq_divider_32_bit;
    localparam int unsigned W      = 32;
    localparam int unsigned NRAND  = 1000;
    localparam int          LAT    = W + 1;  // negedge index of done after the accepting edge
    localparam int          PERIOD = W + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_divider_32_bit_if #(.WIDTH(W)) bus ();
    seq_divider_32_bit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    logic [W-1:0] ra [NRAND];
    logic [W-1:0] rb [NRAND];

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? '1 : a / b;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? a : a % b;
    endfunction

    // Present operands with start for one edge, then scramble the inputs.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    // Negedges until done is seen; -1 if the bound expires.
    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.done && k < 200);
        if (!bus.done) k = -1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2;
        nvec++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            nerr++; $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.div_by_zero});
        end
        nvec++;
        if (bus.quotient !== '0) begin
            nerr++; $display("FAIL reset_quotient: got %h expected 0", bus.quotient);
        end
        nvec++;
        if (bus.remainder !== '0) begin
            nerr++; $display("FAIL reset_remainder: got %h expected 0", bus.remainder);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            nerr++; $display("FAIL reset_idle: got busy/done %b expected 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_basic();
        int k;
        issue(32'd100, 32'd7);
        wait_done(k);
        nvec++;
        if (k != LAT) begin
            nerr++; $display("FAIL t1_latency: got %0d expected %0d", k, LAT);
        end
        nvec++;
        if (bus.quotient !== 32'd14) begin
            nerr++; $display("FAIL t1_quotient: got %0d expected 14", bus.quotient);
        end
        nvec++;
        if (bus.remainder !== 32'd2) begin
            nerr++; $display("FAIL t1_remainder: got %0d expected 2", bus.remainder);
        end
        nvec++;
        if ({bus.div_by_zero, bus.busy} !== 2'b01) begin
            nerr++; $display("FAIL t1_dbz_busy: got %b expected 01", {bus.div_by_zero, bus.busy});
        end
        @(negedge clk);
        nvec++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            nerr++; $display("FAIL t1_after_done: got done/busy %b expected 00", {bus.done, bus.busy});
        end
        nvec++;
        if (bus.quotient !== 32'd14) begin
            nerr++; $display("FAIL t1_hold: got %0d expected 14", bus.quotient);
        end
    endtask

    task automatic test_div_zero();
        int k;
        issue(32'd5, 32'd0);
        wait_done(k);
        nvec++;
        if (k != 1) begin
            nerr++; $display("FAIL t2_latency: got %0d expected 1", k);
        end
        nvec++;
        if (bus.quotient !== 32'hFFFF_FFFF) begin
            nerr++; $display("FAIL t2_quotient: got %h expected ffffffff", bus.quotient);
        end
        nvec++;
        if (bus.remainder !== 32'd5) begin
            nerr++; $display("FAIL t2_remainder: got %0d expected 5", bus.remainder);
        end
        nvec++;
        if (bus.div_by_zero !== 1'b1) begin
            nerr++; $display("FAIL t2_dbz: got %b expected 1", bus.div_by_zero);
        end
        @(negedge clk);
        nvec++;
        if ({bus.done, bus.div_by_zero} !== 2'b01) begin
            nerr++; $display("FAIL t2_dbz_hold: got done/dbz %b expected 01", {bus.done, bus.div_by_zero});
        end
        issue(32'd9, 32'd3);
        nvec++;
        if ({bus.busy, bus.div_by_zero} !== 2'b10) begin
            nerr++; $display("FAIL t2_dbz_clear: got busy/dbz %b expected 10", {bus.busy, bus.div_by_zero});
        end
        wait_done(k);
        nvec++;
        if (k != LAT) begin
            nerr++; $display("FAIL t2_latency2: got %0d expected %0d", k, LAT);
        end
        nvec++;
        if ({bus.quotient, bus.remainder} !== {32'd3, 32'd0}) begin
            nerr++; $display("FAIL t2_9div3: got q=%0d r=%0d expected q=3 r=0", bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] ta [6];
        logic [W-1:0] tb [6];
        int k;
        ta = '{32'hFFFF_FFFF, 32'd3,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd7};
        tb = '{32'd1,         32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd7};
        for (int i = 0; i < 6; i++) begin
            issue(ta[i], tb[i]);
            wait_done(k);
            nvec++;
            if (k != LAT) begin
                nerr++; $display("FAIL t3_latency[%0d]: got %0d expected %0d", i, k, LAT);
            end
            nvec++;
            if (bus.quotient !== ref_q(ta[i], tb[i])) begin
                nerr++; $display("FAIL t3_quotient[%0d]: got %h expected %h", i, bus.quotient, ref_q(ta[i], tb[i]));
            end
            nvec++;
            if (bus.remainder !== ref_r(ta[i], tb[i])) begin
                nerr++; $display("FAIL t3_remainder[%0d]: got %h expected %h", i, bus.remainder, ref_r(ta[i], tb[i]));
            end
        end
    endtask

    task automatic test_busy_ignore();
        int dones = 0;
        int first = -1;
        int busy_low = 0;
        issue(32'd1000, 32'd3);
        for (int k = 1; k <= LAT + 6; k++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (first < 0) first = k;
            end
            if (k <= LAT && !bus.busy) busy_low++;
            if (k == 10) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd50;
                bus.divisor  = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
        end
        nvec++;
        if (dones != 1) begin
            nerr++; $display("FAIL t4_done_count: got %0d expected 1", dones);
        end
        nvec++;
        if (first != LAT) begin
            nerr++; $display("FAIL t4_latency: got %0d expected %0d", first, LAT);
        end
        nvec++;
        if (busy_low != 0) begin
            nerr++; $display("FAIL t4_busy: got %0d idle cycles expected 0", busy_low);
        end
        nvec++;
        if ({bus.quotient, bus.remainder} !== {32'd333, 32'd1}) begin
            nerr++; $display("FAIL t4_result: got q=%0d r=%0d expected q=333 r=1", bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_reset_abort();
        int k;
        int seen = 0;
        issue(32'd1000, 32'd7);
        repeat (15) @(negedge clk);
        nvec++;
        if (bus.busy !== 1'b1) begin
            nerr++; $display("FAIL t5_busy_mid: got %b expected 1", bus.busy);
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== '0) begin
            nerr++; $display("FAIL t5_async_clear: got q=%h r=%h flags=%b expected all 0",
                             bus.quotient, bus.remainder, {bus.busy, bus.done, bus.div_by_zero});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        nvec++;
        if (seen != 0) begin
            nerr++; $display("FAIL t5_no_done: got %0d active cycles expected 0", seen);
        end
        issue(32'd81, 32'd9);
        wait_done(k);
        nvec++;
        if (k != LAT) begin
            nerr++; $display("FAIL t5_latency: got %0d expected %0d", k, LAT);
        end
        nvec++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {32'd9, 32'd0, 1'b0}) begin
            nerr++; $display("FAIL t5_result: got q=%0d r=%0d dbz=%b expected q=9 r=0 dbz=0",
                             bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        int idx_in = 0;
        int idx_out = 0;
        int cyc = 0;
        int last = -1;
        logic prev_busy = 1'b0;
        logic prev_done = 1'b0;
        logic [63:0] recon;
        for (int i = 0; i < NRAND; i++) begin
            ra[i] = (($urandom_range(0, 7)) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       rb[i] = 32'($urandom);
                1:       rb[i] = 32'($urandom_range(1, 255));
                2:       rb[i] = 32'($urandom) | 32'h8000_0000;
                default: rb[i] = 32'd1 << $urandom_range(0, 31);
            endcase
            if (rb[i] == '0) rb[i] = 32'd1;
        end
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = ra[0];
        bus.divisor  = rb[0];
        while (idx_out < int'(NRAND) && cyc < int'(NRAND) * (PERIOD + 4)) begin
            @(negedge clk);
            cyc++;
            if (prev_done) begin
                nvec++;
                if (bus.done !== 1'b0) begin
                    nerr++; $display("FAIL t6_pulse_width[%0d]: got done=%b expected 0", idx_out - 1, bus.done);
                end
            end
            if (bus.busy && !prev_busy) begin
                idx_in++;
                if (idx_in < int'(NRAND)) begin
                    bus.dividend = ra[idx_in];
                    bus.divisor  = rb[idx_in];
                end else begin
                    bus.start = 1'b0;
                end
            end
            if (bus.done) begin
                recon = 64'(bus.quotient) * 64'(rb[idx_out]) + 64'(bus.remainder);
                nvec++;
                if (bus.quotient !== ref_q(ra[idx_out], rb[idx_out])) begin
                    nerr++; $display("FAIL t6_quotient[%0d]: %h/%h got %h expected %h", idx_out,
                                     ra[idx_out], rb[idx_out], bus.quotient, ref_q(ra[idx_out], rb[idx_out]));
                end
                nvec++;
                if (bus.remainder !== ref_r(ra[idx_out], rb[idx_out])) begin
                    nerr++; $display("FAIL t6_remainder[%0d]: %h/%h got %h expected %h", idx_out,
                                     ra[idx_out], rb[idx_out], bus.remainder, ref_r(ra[idx_out], rb[idx_out]));
                end
                nvec++;
                if (recon !== 64'(ra[idx_out]) || bus.remainder >= rb[idx_out]) begin
                    nerr++; $display("FAIL t6_invariant[%0d]: got q*v+r=%h r=%h expected %h with r<%h", idx_out,
                                     recon, bus.remainder, ra[idx_out], rb[idx_out]);
                end
                if (last >= 0) begin
                    nvec++;
                    if (cyc - last != PERIOD) begin
                        nerr++; $display("FAIL t6_period[%0d]: got %0d expected %0d", idx_out, cyc - last, PERIOD);
                    end
                end
                last = cyc;
                idx_out++;
            end
            prev_busy = bus.busy;
            prev_done = bus.done;
        end
        bus.start = 1'b0;
        nvec++;
        if (idx_out != int'(NRAND)) begin
            nerr++; $display("FAIL t6_timeout: got %0d results expected %0d", idx_out, NRAND);
        end
        @(negedge clk);
        nvec++;
        if (bus.done !== 1'b0) begin
            nerr++; $display("FAIL t6_last_pulse: got done=%b expected 0", bus.done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_boundaries();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
